// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : des_round_ctrl
// Purpose  : Sequencer for an iterative 16-round DES core; drives round enable,
//            round index, C/D shift control and the block-level handshakes.
// Revision : 1.0  initial release
// ============================================================================
module des_round_ctrl #(
   parameter int ROUNDS = 16,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_decrypt,
   output logic             ld_data,
   output logic             ld_key,
   output logic             round_en,
   output logic [CNT_W-1:0] round_idx,
   output logic [1:0]       shift_amt,
   output logic             shift_dir,
   output logic             last_round,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] round_idx_q, round_idx_d;
   logic             mode_q, mode_d;
   logic             accept;

   // Key-schedule rotation per round. Decrypt starts from the unrotated C0/D0,
   // which equals C16/D16 because the encrypt shifts sum to a full 28-bit turn.
   function automatic logic [1:0] shift_lookup(input logic [CNT_W-1:0] idx,
                                               input logic             dec);
      logic [1:0] amt;
      amt = 2'd2;
      if (idx == '0) begin
         amt = dec ? 2'd0 : 2'd1;
      end else if (idx == CNT_W'(1) || idx == CNT_W'(8) || idx == CNT_W'(15)) begin
         amt = 2'd1;
      end
      return amt;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         round_idx_q <= '0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_idx_q <= round_idx_d;
         mode_q      <= mode_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      round_idx_d = round_idx_q;
      mode_d      = mode_q;
      in_ready    = 1'b0;
      round_en    = 1'b0;
      last_round  = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      accept      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_ROUND: begin
            busy     = 1'b1;
            round_en = 1'b1;
            if (round_idx_q == LAST_IDX) begin
               last_round  = 1'b1;
               state_d     = ST_DONE;
               round_idx_d = '0;
            end else begin
               round_idx_d = round_idx_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            round_idx_d = '0;
         end
      endcase

      // A new job overrides the DONE->IDLE exit so results can stream without a bubble.
      accept = in_valid & in_ready;
      if (accept) begin
         state_d     = ST_ROUND;
         round_idx_d = '0;
         mode_d      = in_decrypt;
      end
   end

   assign ld_data   = accept;
   assign ld_key    = accept;
   assign round_idx = round_idx_q;
   assign shift_amt = round_en ? shift_lookup(round_idx_q, mode_q) : 2'd0;
   assign shift_dir = (state_q != ST_IDLE) & mode_q;

endmodule
`default_nettype wire
